hdmi_period_seq: RTL and testbench

HDMI_PERIOD_SEQ -- requirements
Module: hdmi_period_seq

---
 rtl/hdmi_period_pkg.sv | 50 +++++
 rtl/hdmi_preamble_cnt.sv | 48 ++++
 rtl/hdmi_period_seq.sv | 255 +++++++++++++++++++++++++
 tb/tb_hdmi_period_seq.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/hdmi_period_pkg.sv
// -----------------------------------------------------------------------------
// hdmi_period_pkg
// Shared types and constants for the HDMI period sequencer.
//   period_t      : period FSM encoding; the value is driven straight out on
//                   hdmi_period_seq.period, so the encoding is fixed.
//   PREAMBLE_LEN  : preamble chars needed before a guard band
//   GB_LEN        : leading video guard band length
//   PKT_LEN       : chars per data-island packet (power of two)
//   MAX_PKTS      : packets allowed in one data island
//   CTL_VID_CH*   : {c1,c0} per channel for a video preamble char
//   CTL_DI_CH*    : {c1,c0} per channel for a data-island preamble char
// -----------------------------------------------------------------------------
package hdmi_period_pkg;

  typedef enum logic [2:0] {
    CTRL     = 3'd0,
    PRE_VID  = 3'd1,
    VID_GB   = 3'd2,
    VIDEO    = 3'd3,
    PRE_DI   = 3'd4,
    DI_LEAD  = 3'd5,
    DI_BODY  = 3'd6,
    DI_TRAIL = 3'd7
  } period_t;

  localparam int PREAMBLE_LEN = 8;
  localparam int GB_LEN       = 2;
  localparam int PKT_LEN      = 32;
  localparam int MAX_PKTS     = 18;
  localparam int BODY_MAX     = PKT_LEN * MAX_PKTS;
  localparam int PKT_IDX_W    = $clog2(PKT_LEN);

  localparam logic [1:0] CTL_VID_CH1 = 2'b01;
  localparam logic [1:0] CTL_VID_CH2 = 2'b00;
  localparam logic [1:0] CTL_DI_CH1  = 2'b01;
  localparam logic [1:0] CTL_DI_CH2  = 2'b01;

  // A preamble char is a control char on channels 1 and 2 whose {c1,c0}
  // codes match the given pair. Channel 0 carries sync and is ignored.
  function automatic logic is_preamble(input logic [1:0] ctl_vld_hi,
                                       input logic [1:0] c0_hi,
                                       input logic [1:0] c1_hi,
                                       input logic [1:0] ch1_code,
                                       input logic [1:0] ch2_code);
    return (ctl_vld_hi == 2'b11) &&
           ({c1_hi[0], c0_hi[0]} == ch1_code) &&
           ({c1_hi[1], c0_hi[1]} == ch2_code);
  endfunction

endpackage

// File: rtl/hdmi_preamble_cnt.sv
// -----------------------------------------------------------------------------
// hdmi_preamble_cnt
// Classifies the current control char as a video or island preamble and keeps
// the saturating preamble length counter.
// Ports:
//   pclk, reset   : pixel clock, synchronous active-high reset
//   clr           : synchronous clear (link not locked)
//   load          : restart the count at 1 (first char of a new preamble)
//   inc           : count one more matching preamble char (saturates)
//   ctl_vld_hi    : ctl_vld[2:1] of the decoders
//   c0_hi, c1_hi  : c0[2:1] / c1[2:1] of the decoders
//   vid_pre       : current char is a video preamble char
//   di_pre        : current char is a data-island preamble char
//   pre_full      : PREAMBLE_LEN preamble chars have been seen
// -----------------------------------------------------------------------------
module hdmi_preamble_cnt
  import hdmi_period_pkg::*;
(
  input  logic       pclk,
  input  logic       reset,
  input  logic       clr,
  input  logic       load,
  input  logic       inc,
  input  logic [1:0] ctl_vld_hi,
  input  logic [1:0] c0_hi,
  input  logic [1:0] c1_hi,
  output logic       vid_pre,
  output logic       di_pre,
  output logic       pre_full
);

  logic [3:0] pre_cnt;

  assign vid_pre  = is_preamble(ctl_vld_hi, c0_hi, c1_hi, CTL_VID_CH1, CTL_VID_CH2);
  assign di_pre   = is_preamble(ctl_vld_hi, c0_hi, c1_hi, CTL_DI_CH1, CTL_DI_CH2);
  assign pre_full = (pre_cnt == 4'(PREAMBLE_LEN));

  always_ff @(posedge pclk) begin
    if (reset || clr) begin
      pre_cnt <= '0;
    end else if (load) begin
      pre_cnt <= 4'd1;
    end else if (inc && !pre_full) begin
      pre_cnt <= pre_cnt + 4'd1;
    end
  end

endmodule

// File: rtl/hdmi_period_seq.sv
// -----------------------------------------------------------------------------
// hdmi_period_seq
// Tracks which HDMI period (control, video, data island) the TMDS stream is in,
// checks preamble / guard band / packet framing and flags protocol violations.
// All outputs are registered: the response to a char appears one pclk later.
//
// Ports:
//   pclk       in   pixel clock
//   reset      in   synchronous active-high reset (overrides everything)
//   lock       in   all three channel decoders ready; low forces CTRL
//   de, ctl_vld, c0, c1, dgb, vgb  in [2:0]  per-channel decoder flags
//   period     out  [2:0] current period (period_t encoding)
//   pkt_start  out  pulse on the first body char of each packet
//   pkt_idx    out  [4:0] char index within the current packet
//   hdmi_mode  out  sticky, set after one well-formed data island
//   seq_err    out  pulse on a protocol violation
//   rekey      out  pulse on VIDEO -> CTRL
//
// Build option: HDCP_REKEY_EN -- when defined, rekey pulses on the same edge
// that period leaves VIDEO for CTRL; otherwise rekey is tied low.
//
// state    | meaning
// ---------+---------------------------------------------------------
// CTRL     | control period, waiting for a preamble or DVI video
// PRE_VID  | counting video preamble chars
// VID_GB   | inside the leading video guard band
// VIDEO    | active video
// PRE_DI   | counting data-island preamble chars
// DI_LEAD  | inside the leading data-island guard band
// DI_BODY  | data-island packet chars
// DI_TRAIL | inside the trailing data-island guard band
// -----------------------------------------------------------------------------
module hdmi_period_seq
  import hdmi_period_pkg::*;
(
  input  logic       pclk,
  input  logic       reset,
  input  logic       lock,
  input  logic [2:0] de,
  input  logic [2:0] ctl_vld,
  input  logic [2:0] c0,
  input  logic [2:0] c1,
  input  logic [2:0] dgb,
  input  logic [2:0] vgb,
  output logic [2:0] period,
  output logic       pkt_start,
  output logic [4:0] pkt_idx,
  output logic       hdmi_mode,
  output logic       seq_err,
  output logic       rekey
);

  period_t    state_q, state_d;
  logic [1:0] gb_cnt_q, gb_cnt_d;
  logic [9:0] body_cnt_q, body_cnt_d;

  logic pre_load, pre_inc;
  logic vid_pre, di_pre, pre_full;
  logic err_d, body_chr, island_done;

  logic de_all, de_pair, vgb_all, dgb_pair, pkt_boundary;

  // Channel 0 carries sync/TERC4 inside islands, so island checks use ch1/ch2.
  assign de_all       = (de == 3'b111);
  assign de_pair      = (de[2:1] == 2'b11);
  assign vgb_all      = (vgb == 3'b111);
  assign dgb_pair     = (dgb[2:1] == 2'b11);
  assign pkt_boundary = (body_cnt_q != '0) && (body_cnt_q[PKT_IDX_W-1:0] == '0);

  logic unused_chan0;
  assign unused_chan0 = ^{c0[0], c1[0], dgb[0]};

  hdmi_preamble_cnt u_pre_cnt (
    .pclk       (pclk),
    .reset      (reset),
    .clr        (!lock),
    .load       (pre_load),
    .inc        (pre_inc),
    .ctl_vld_hi (ctl_vld[2:1]),
    .c0_hi      (c0[2:1]),
    .c1_hi      (c1[2:1]),
    .vid_pre    (vid_pre),
    .di_pre     (di_pre),
    .pre_full   (pre_full)
  );

  always_comb begin
    state_d     = state_q;
    gb_cnt_d    = gb_cnt_q;
    body_cnt_d  = body_cnt_q;
    pre_load    = 1'b0;
    pre_inc     = 1'b0;
    err_d       = 1'b0;
    body_chr    = 1'b0;
    island_done = 1'b0;

    case (state_q)
      CTRL: begin
        if (vid_pre) begin
          state_d  = PRE_VID;
          pre_load = 1'b1;
        end else if (di_pre) begin
          state_d  = PRE_DI;
          pre_load = 1'b1;
        end else if (de_all) begin
          state_d = VIDEO;
        end
      end

      PRE_VID: begin
        if (vid_pre) begin
          pre_inc = 1'b1;
        end else if (di_pre) begin
          state_d  = PRE_DI;
          pre_load = 1'b1;
        end else if (vgb_all) begin
          if (pre_full) begin
            state_d  = VID_GB;
            gb_cnt_d = 2'd1;
          end else begin
            state_d = CTRL;
            err_d   = 1'b1;
          end
        end else begin
          state_d = CTRL;
        end
      end

      VID_GB: begin
        if (vgb_all && (gb_cnt_q != 2'(GB_LEN))) begin
          gb_cnt_d = gb_cnt_q + 2'd1;
        end else if (de_all && (gb_cnt_q == 2'(GB_LEN))) begin
          state_d = VIDEO;
        end else begin
          state_d = CTRL;
          err_d   = 1'b1;
        end
      end

      VIDEO: begin
        if (!de_all) begin
          state_d = CTRL;
          err_d   = (ctl_vld == 3'b000);
        end
      end

      PRE_DI: begin
        if (di_pre) begin
          pre_inc = 1'b1;
        end else if (vid_pre) begin
          state_d  = PRE_VID;
          pre_load = 1'b1;
        end else if (dgb_pair) begin
          if (pre_full) begin
            state_d = DI_LEAD;
          end else begin
            state_d = CTRL;
            err_d   = 1'b1;
          end
        end else begin
          state_d = CTRL;
        end
      end

      DI_LEAD: begin
        if (dgb_pair) begin
          state_d    = DI_BODY;
          body_cnt_d = '0;
        end else begin
          state_d = CTRL;
          err_d   = 1'b1;
        end
      end

      DI_BODY: begin
        // A trailing guard band is only legal on a packet boundary; once the
        // island has carried MAX_PKTS packets nothing but the guard band fits.
        if (dgb_pair) begin
          if (pkt_boundary) begin
            state_d = DI_TRAIL;
          end else begin
            state_d = CTRL;
            err_d   = 1'b1;
          end
        end else if (body_cnt_q == 10'(BODY_MAX)) begin
          state_d = CTRL;
          err_d   = 1'b1;
        end else if (de_pair) begin
          body_chr   = 1'b1;
          body_cnt_d = body_cnt_q + 10'd1;
        end else begin
          state_d = CTRL;
          err_d   = 1'b1;
        end
      end

      DI_TRAIL: begin
        state_d = CTRL;
        if (dgb_pair) begin
          island_done = 1'b1;
        end else begin
          err_d = 1'b1;
        end
      end

      default: begin
        state_d = CTRL;
      end
    endcase
  end

  // Losing lock is not a protocol error: it wipes everything and masks pulses.
  always_ff @(posedge pclk) begin
    if (reset || !lock) begin
      state_q    <= CTRL;
      gb_cnt_q   <= '0;
      body_cnt_q <= '0;
      pkt_start  <= 1'b0;
      pkt_idx    <= '0;
      hdmi_mode  <= 1'b0;
      seq_err    <= 1'b0;
    end else begin
      state_q    <= state_d;
      gb_cnt_q   <= gb_cnt_d;
      body_cnt_q <= body_cnt_d;
      pkt_start  <= body_chr && (body_cnt_q[PKT_IDX_W-1:0] == '0);
      // pkt_idx reports the index of the char just accepted and holds while
      // the island body continues; it reads 0 outside the body.
      if (body_chr) begin
        pkt_idx <= body_cnt_q[PKT_IDX_W-1:0];
      end else if (state_d != DI_BODY) begin
        pkt_idx <= '0;
      end
      if (island_done) begin
        hdmi_mode <= 1'b1;
      end
      seq_err <= err_d;
    end
  end

`ifdef HDCP_REKEY_EN
  always_ff @(posedge pclk) begin
    if (reset || !lock) begin
      rekey <= 1'b0;
    end else begin
      rekey <= (state_q == VIDEO) && (state_d == CTRL);
    end
  end
`else
  assign rekey = 1'b0;
`endif

  assign period = state_q;

endmodule

// File: tb/tb_hdmi_period_seq.sv
module tb_hdmi_period_seq;

  logic       pclk;
  logic       reset;
  logic       lock;
  logic [2:0] de, ctl_vld, c0, c1, dgb, vgb;
  logic [2:0] period;
  logic       pkt_start;
  logic [4:0] pkt_idx;
  logic       hdmi_mode;
  logic       seq_err;
  logic       rekey;

  int chk_cnt  = 0;
  int pass_cnt = 0;

`ifdef HDCP_REKEY_EN
  localparam bit REKEY_ON = 1'b1;
`else
  localparam bit REKEY_ON = 1'b0;
`endif

  typedef enum int {K_IDLE, K_CTL0, K_VPRE, K_IPRE, K_VGB, K_DGB, K_DE, K_BODY} kind_t;

  // rep copies of one char; expected pkt_start/pkt_idx/hdmi_mode are 0 here.
  typedef struct {
    int         rep;
    bit         rst;
    bit         lk;
    kind_t      k;
    logic [2:0] per;
    bit         err;
    bit         rk;
  } vec_t;

  vec_t vq[$];

  hdmi_period_seq dut (
    .pclk      (pclk),
    .reset     (reset),
    .lock      (lock),
    .de        (de),
    .ctl_vld   (ctl_vld),
    .c0        (c0),
    .c1        (c1),
    .dgb       (dgb),
    .vgb       (vgb),
    .period    (period),
    .pkt_start (pkt_start),
    .pkt_idx   (pkt_idx),
    .hdmi_mode (hdmi_mode),
    .seq_err   (seq_err),
    .rekey     (rekey)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic drive(input kind_t k);
    de = '0; ctl_vld = '0; c0 = '0; c1 = '0; dgb = '0; vgb = '0;
    case (k)
      K_CTL0: ctl_vld = 3'b111;
      K_VPRE: begin ctl_vld = 3'b111; c0 = 3'b010; end
      K_IPRE: begin ctl_vld = 3'b111; c0 = 3'b110; end
      K_VGB:  vgb = 3'b111;
      K_DGB:  dgb = 3'b110;
      K_DE:   de = 3'b111;
      K_BODY: de = 3'b110;
      default: ;
    endcase
  endtask

  task automatic step(input kind_t k, input bit lk, input bit rst,
                      input logic [2:0] per, input bit st, input logic [4:0] idx,
                      input bit hm, input bit err, input bit rk, input string tag);
    logic [11:0] got, exp;
    drive(k);
    lock  = lk;
    reset = rst;
    @(posedge pclk);
    #1;
    exp = {per, st, idx, hm, err, rk & REKEY_ON};
    got = {period, pkt_start, pkt_idx, hdmi_mode, seq_err, rekey};
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got period=%0d pkt_start=%0b pkt_idx=%0d hdmi_mode=%0b seq_err=%0b rekey=%0b, want period=%0d pkt_start=%0b pkt_idx=%0d hdmi_mode=%0b seq_err=%0b rekey=%0b",
                  tag, period, pkt_start, pkt_idx, hdmi_mode, seq_err, rekey,
                  exp[11:9], exp[8], exp[7:3], exp[2], exp[1], exp[0]);
  endtask

  task automatic island_head(input bit hm, input string tag);
    for (int i = 0; i < 8; i++) step(K_IPRE, 1, 0, 3'd4, 0, 5'd0, hm, 0, 0, {tag, "_pre"});
    step(K_DGB, 1, 0, 3'd5, 0, 5'd0, hm, 0, 0, {tag, "_lead1"});
    step(K_DGB, 1, 0, 3'd6, 0, 5'd0, hm, 0, 0, {tag, "_lead2"});
  endtask

  task automatic body_run(input int n, input bit hm, input string tag);
    for (int i = 0; i < n; i++)
      step(K_BODY, 1, 0, 3'd6, (i % 32) == 0, 5'(i % 32), hm, 0, 0,
           $sformatf("%s_body%0d", tag, i));
  endtask

  initial begin
    reset = 1'b1;
    lock  = 1'b1;
    drive(K_IDLE);

    //           rep rst lk  char    per  err rk
    vq.push_back('{2, 1, 1, K_IDLE, 3'd0, 0, 0});   // reset
    vq.push_back('{8, 0, 1, K_VPRE, 3'd1, 0, 0});   // full video entry
    vq.push_back('{2, 0, 1, K_VGB,  3'd2, 0, 0});
    vq.push_back('{4, 0, 1, K_DE,   3'd3, 0, 0});
    vq.push_back('{1, 0, 1, K_CTL0, 3'd0, 0, 1});   // video end, rekey
    vq.push_back('{1, 0, 1, K_IDLE, 3'd0, 0, 0});
    vq.push_back('{6, 0, 1, K_VPRE, 3'd1, 0, 0});   // short video preamble
    vq.push_back('{1, 0, 1, K_VGB,  3'd0, 1, 0});
    vq.push_back('{1, 0, 1, K_CTL0, 3'd0, 0, 0});
    vq.push_back('{10,0, 1, K_VPRE, 3'd1, 0, 0});   // saturating count
    vq.push_back('{1, 0, 1, K_VGB,  3'd2, 0, 0});
    vq.push_back('{1, 0, 1, K_DE,   3'd0, 1, 0});   // video after one gb
    vq.push_back('{1, 0, 1, K_VPRE, 3'd1, 0, 0});   // preamble type switching
    vq.push_back('{3, 0, 1, K_IPRE, 3'd4, 0, 0});
    vq.push_back('{1, 0, 1, K_VPRE, 3'd1, 0, 0});
    vq.push_back('{8, 0, 1, K_IPRE, 3'd4, 0, 0});
    vq.push_back('{1, 0, 1, K_DGB,  3'd5, 0, 0});
    vq.push_back('{1, 0, 1, K_CTL0, 3'd0, 1, 0});   // broken leading gb
    vq.push_back('{5, 0, 1, K_IPRE, 3'd4, 0, 0});   // short island preamble
    vq.push_back('{1, 0, 1, K_DGB,  3'd0, 1, 0});
    vq.push_back('{8, 0, 1, K_VPRE, 3'd1, 0, 0});   // switch restarts count
    vq.push_back('{1, 0, 1, K_IPRE, 3'd4, 0, 0});
    vq.push_back('{1, 0, 1, K_DGB,  3'd0, 1, 0});
    vq.push_back('{1, 0, 1, K_DE,   3'd3, 0, 0});   // DVI path
    vq.push_back('{2, 0, 1, K_DE,   3'd3, 0, 0});
    vq.push_back('{1, 0, 1, K_IDLE, 3'd0, 1, 1});   // non-ctl char ends video
    vq.push_back('{1, 0, 1, K_CTL0, 3'd0, 0, 0});
    vq.push_back('{8, 0, 1, K_VPRE, 3'd1, 0, 0});   // lock loss in video
    vq.push_back('{2, 0, 1, K_VGB,  3'd2, 0, 0});
    vq.push_back('{1, 0, 1, K_DE,   3'd3, 0, 0});
    vq.push_back('{1, 0, 0, K_IDLE, 3'd0, 0, 0});   // lock beats violation
    vq.push_back('{1, 0, 1, K_CTL0, 3'd0, 0, 0});
    vq.push_back('{3, 0, 1, K_VPRE, 3'd1, 0, 0});   // plain ctl char in preamble
    vq.push_back('{1, 0, 1, K_CTL0, 3'd0, 0, 0});
    vq.push_back('{8, 0, 1, K_VPRE, 3'd1, 0, 0});   // third vgb
    vq.push_back('{2, 0, 1, K_VGB,  3'd2, 0, 0});
    vq.push_back('{1, 0, 1, K_VGB,  3'd0, 1, 0});

    foreach (vq[i])
      for (int r = 0; r < vq[i].rep; r++)
        step(vq[i].k, vq[i].lk, vq[i].rst, vq[i].per, 0, 5'd0, 0, vq[i].err, vq[i].rk,
             $sformatf("vec%0d.%0d", i, r));

    // Two-packet island, closes cleanly and sets hdmi_mode
    island_head(0, "isl64");
    body_run(64, 0, "isl64");
    step(K_DGB,  1, 0, 3'd7, 0, 5'd0, 0, 0, 0, "isl64_trail1");
    step(K_DGB,  1, 0, 3'd0, 0, 5'd0, 1, 0, 0, "isl64_trail2");
    step(K_CTL0, 1, 0, 3'd0, 0, 5'd0, 1, 0, 0, "isl64_sticky");

    // Trailing gb off a packet boundary
    island_head(1, "isl40");
    body_run(40, 1, "isl40");
    step(K_DGB,  1, 0, 3'd0, 0, 5'd0, 1, 1, 0, "isl40_bad_trail");
    step(K_CTL0, 1, 0, 3'd0, 0, 5'd0, 1, 0, 0, "isl40_after");

    // Maximum island length: trailing gb is still legal at 576
    island_head(1, "islmax");
    body_run(576, 1, "islmax");
    step(K_DGB, 1, 0, 3'd7, 0, 5'd0, 1, 0, 0, "islmax_trail1");
    step(K_DGB, 1, 0, 3'd0, 0, 5'd0, 1, 0, 0, "islmax_trail2");

    // One body char too many
    island_head(1, "islovf");
    body_run(576, 1, "islovf");
    step(K_BODY, 1, 0, 3'd0, 0, 5'd0, 1, 1, 0, "islovf_extra");

    // DVI entry, then lock lost at body char 10
    step(K_DE,   1, 0, 3'd3, 0, 5'd0, 1, 0, 0, "dvi_video");
    step(K_CTL0, 1, 0, 3'd0, 0, 5'd0, 1, 0, 1, "dvi_end");
    island_head(1, "islunlk");
    body_run(10, 1, "islunlk");
    step(K_BODY, 0, 0, 3'd0, 0, 5'd0, 0, 0, 0, "islunlk_drop");
    step(K_IDLE, 1, 0, 3'd0, 0, 5'd0, 0, 0, 0, "islunlk_relock");

    // Reset in the middle of an island body after hdmi_mode was set
    island_head(0, "islrst_a");
    body_run(32, 0, "islrst_a");
    step(K_DGB, 1, 0, 3'd7, 0, 5'd0, 0, 0, 0, "islrst_a_trail1");
    step(K_DGB, 1, 0, 3'd0, 0, 5'd0, 1, 0, 0, "islrst_a_trail2");
    island_head(1, "islrst_b");
    body_run(5, 1, "islrst_b");
    step(K_BODY, 1, 1, 3'd0, 0, 5'd0, 0, 0, 0, "islrst_b_reset");
    step(K_IDLE, 1, 0, 3'd0, 0, 5'd0, 0, 0, 0, "islrst_b_after");

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
